// File: rtl/mult_pkg.sv
// Shared definitions for the sequential signed shift-add multiplier:
// controller state encoding, default operand width and the round-robin pick.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SIGN  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // last_served = index of the requester granted most recently; on a tie the other one wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_served);
    logic [1:0] win;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_served ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/mult_sched_rr_arb2.sv
// Two-input round-robin arbiter. The winner is combinational from req; the
// last-served pointer advances only on the update strobe (controller entering LOAD).
module rr_arb2
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] win
);

  logic last_q;
  logic last_d;

  // Winner selection and pointer next-value.
  always_comb begin
    win    = rr_pick(req, last_q);
    last_d = last_q;
    if (upd) begin
      last_d = win[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset value makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Controller and two-requester scheduler for the shift-add multiplier datapath:
// arbitration, LOAD/SHIFT/SIGN/DONE sequencing, early exit on zero multiplier.
module mult_sched
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       prod_neg,
  input  logic       z_flag_multiplier,
  output logic [1:0] gnt,
  output logic       load,
  output logic       reg_en,
  output logic       shift_en,
  output logic       psel,
  output logic       neg_en,
  output logic       busy,
  output logic       done,
  output logic       led
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [IW-1:0] iter_q, iter_d;
  logic          neg_q, neg_d;

  logic [1:0]    arb_win;
  logic          arb_upd;
  logic          req_live;
  logic          shift_now;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .upd   (arb_upd),
    .win   (arb_win)
  );

  assign req_live  = |(req & gnt_q);
  assign shift_now = (state_q == ST_SHIFT) && !z_flag_multiplier;

  // Next-state, grant, iteration counter and sign latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    iter_d  = iter_q;
    neg_d   = neg_q;
    arb_upd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_LOAD;
          gnt_d   = arb_win;
          arb_upd = 1'b1;
        end else begin
          gnt_d   = 2'b00;
        end
      end
      ST_LOAD: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else begin
          state_d = ST_SHIFT;
          neg_d   = prod_neg;
          iter_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else if (!shift_now) begin
          state_d = ST_SIGN;
        end else begin
          iter_d = iter_q + IW'(1);
          // The WIDTH-th shift ends the job even if the multiplier never reads zero.
          if (iter_q == ITER_LAST) begin
            state_d = ST_SIGN;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SIGN: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!req_live) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      iter_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      iter_q  <= iter_d;
      neg_q   <= neg_d;
    end
  end

  // Datapath controls decoded from registered state only (shift_en also sees z_flag).
  always_comb begin
    gnt      = gnt_q;
    load     = 1'b0;
    reg_en   = 1'b0;
    shift_en = 1'b0;
    psel     = 1'b0;
    neg_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOAD: begin
        load   = 1'b1;
        reg_en = 1'b1;
        busy   = 1'b1;
      end
      ST_SHIFT: begin
        reg_en   = 1'b1;
        psel     = 1'b1;
        shift_en = shift_now;
        busy     = 1'b1;
      end
      ST_SIGN: begin
        reg_en = 1'b1;
        psel   = 1'b1;
        neg_en = neg_q;
        busy   = 1'b1;
      end
      ST_DONE: begin
        psel = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    led = done;
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: scoreboard of expected grant/shift/sign/latency
// per job, round-robin model, abort and mid-job reset scenarios.
module tb_mult_sched;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic       prod_neg;
  logic       z_flag_multiplier;
  logic [1:0] gnt;
  logic       load, reg_en, shift_en, psel, neg_en, busy, done, led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] g;
    int         shifts;
    int         negs;
    int         lat;
  } exp_t;

  exp_t sb_q[$];

  int   shifts;
  int   z_after;
  logic model_last;

  mult_sched #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .prod_neg          (prod_neg),
    .z_flag_multiplier (z_flag_multiplier),
    .gnt               (gnt),
    .load              (load),
    .reg_en            (reg_en),
    .shift_en          (shift_en),
    .psel              (psel),
    .neg_en            (neg_en),
    .busy              (busy),
    .done              (done),
    .led               (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: update the emulated zero flag just after the edge, sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    z_flag_multiplier = (shifts >= z_after);
    #1;
  endtask

  function automatic logic [1:0] model_grant(input logic [1:0] r);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
    return (model_last == 1'b0) ? 2'b10 : 2'b01;
  endfunction

  // Run one complete job; r is driven now, the granted bit is dropped after done.
  task automatic run_job(input logic [1:0] r, input int za, input logic pn);
    exp_t       e, got;
    int         s_cyc, loads, negs, busy_cyc, lat;
    logic [1:0] g_obs;
    logic       seen, saw_load, flipped;
    e.g      = model_grant(r);
    s_cyc    = (za >= W) ? W : za + 1;
    e.shifts = (za >= W) ? W : za;
    e.negs   = pn ? 1 : 0;
    e.lat    = 3 + s_cyc;
    sb_q.push_back(e);
    model_last = e.g[1];

    req = r; prod_neg = pn; z_after = za; shifts = 0;
    loads = 0; negs = 0; busy_cyc = 0; lat = 0; g_obs = 2'b00;
    seen = 1'b0; saw_load = 1'b0; flipped = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (load) begin
        loads++;
        g_obs    = gnt;
        saw_load = 1'b1;
      end else if (saw_load && !flipped) begin
        prod_neg = ~pn;
        flipped  = 1'b1;
      end
      if (shift_en) shifts++;
      if (neg_en) negs++;
      if (busy) busy_cyc++;
      if (done) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", seen, 1'b1);
    got = sb_q.pop_front();
    chk("grant", g_obs, got.g);
    chk("load_cycles", loads, 1);
    chk("shift_count", shifts, got.shifts);
    chk("neg_en_pulses", negs, got.negs);
    chk("done_latency", lat, got.lat);
    chk("busy_cycles", busy_cyc, got.lat - 1);
    chk("led_eq_done", led, done);
    chk("gnt_held_done", gnt, got.g);

    step();
    chk("done_held", done, 1'b1);
    req = req & ~got.g;
    step();
    chk("idle_done", done, 1'b0);
    chk("idle_gnt", gnt, 2'b00);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; prod_neg = 1'b0; z_flag_multiplier = 1'b0;
    shifts = 0; z_after = 1000; model_last = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outputs", {gnt, load, reg_en, shift_en, psel, neg_en, busy, done, led}, 10'd0);
    rst_n = 1'b1;

    // Ties with both requests re-raised: 01, 10, 01.
    run_job(2'b11, 2, 1'b0);
    run_job(2'b11, 5, 1'b1);
    run_job(2'b11, 0, 1'b0);

    // Full-width job, zero flag never rises; sign latched before the live input flips.
    run_job(2'b01, 1000, 1'b1);
    run_job(2'b01, 1000, 1'b0);
    // Zero multiplier from the first SHIFT cycle: minimum job.
    run_job(2'b10, 0, 1'b1);
    // Zero flag appears exactly at the width cap.
    run_job(2'b10, W, 1'b0);

    // Reset asserted mid-SHIFT after three shifts.
    req = 2'b01; prod_neg = 1'b1; z_after = 1000; shifts = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (shift_en) shifts++;
      if (shifts == 3) break;
    end
    chk("midjob_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midjob_rst_outputs", {gnt, load, reg_en, shift_en, psel, neg_en, busy, done, led}, 10'd0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(posedge clk);
    #2;
    run_job(2'b01, 3, 1'b1);

    // Abort: granted requester drops at iter=4, the other one is served next.
    begin
      logic [1:0] g_exp, g_obs;
      logic       done_any;
      g_exp = model_grant(2'b11);
      model_last = g_exp[1];
      req = 2'b11; z_after = 1000; shifts = 0; g_obs = 2'b00; done_any = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (load) g_obs = gnt;
        if (shift_en) shifts++;
        if (done) done_any = 1'b1;
        if (shifts == 4) break;
      end
      chk("abort_grant", g_obs, g_exp);
      chk("abort_shifts", shifts, 4);
      req = req & ~g_exp;
      step();
      chk("abort_idle_busy", busy, 1'b0);
      chk("abort_gnt_clear", gnt, 2'b00);
      chk("abort_no_done", done_any | done, 1'b0);
      run_job(req, 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
